// File: rtl/fp_add_sub_pipe.sv
// fp_add_sub_pipe: three-stage pipelined floating-point adder/subtractor.
// Truncating arithmetic, subnormal operands flushed to zero, Inf/NaN operands and
// exponent overflow reported through exception with a zero result.
module fp_add_sub_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         exception
);

  // Mantissa datapath: carry bit, hidden bit, stored fraction.
  localparam int unsigned DpW = MAN_W + 2;
  localparam int unsigned ShW = $clog2(DpW);
  // Exponent math needs headroom for the carry increment and a negative underflow.
  localparam int unsigned ExW = EXP_W + 2;
  localparam logic [EXP_W-1:0] ExpMax = '1;

  logic advance;

  // Stage 1 signals.
  logic             sign_a, sign_b, zero_a, zero_b, inf_any, a_larger;
  logic [EXP_W-1:0] exp_a, exp_b, exp_l, exp_s, exp_diff;
  logic [MAN_W-1:0] man_a, man_b;
  logic [DpW-1:0]   mant_l, mant_s, mant_s_al;

  logic             s1_valid_q, s1_sign_q, s1_sub_q, s1_inf_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [DpW-1:0]   s1_mant_l_q, s1_mant_s_q;

  // Stage 2 signals.
  logic [DpW-1:0]   sum_d;
  logic             s2_valid_q, s2_sign_q, s2_inf_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [DpW-1:0]   s2_sum_q;

  // Stage 3 signals.
  logic [ShW-1:0]   lz;
  logic [ExW-1:0]   exp_n;
  logic [DpW-1:0]   man_n;
  logic [W-1:0]     res_d;
  logic             exc_d;
  logic             out_valid_q, exc_q;
  logic [W-1:0]     res_q;

  // Global stall: the whole pipe moves only when the output slot can drain.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // Unpack, fold op into b's sign, order by magnitude and align the smaller operand.
  always_comb begin
    sign_a   = a[W-1];
    sign_b   = b[W-1] ^ op;
    exp_a    = a[W-2 -: EXP_W];
    exp_b    = b[W-2 -: EXP_W];
    zero_a   = (exp_a == '0);
    zero_b   = (exp_b == '0);
    inf_any  = (exp_a == ExpMax) || (exp_b == ExpMax);
    man_a    = zero_a ? '0 : a[MAN_W-1:0];
    man_b    = zero_b ? '0 : b[MAN_W-1:0];
    a_larger = ({exp_a, man_a} >= {exp_b, man_b});
    if (a_larger) begin
      exp_l  = exp_a;
      exp_s  = exp_b;
      mant_l = {1'b0, ~zero_a, man_a};
      mant_s = {1'b0, ~zero_b, man_b};
    end else begin
      exp_l  = exp_b;
      exp_s  = exp_a;
      mant_l = {1'b0, ~zero_b, man_b};
      mant_s = {1'b0, ~zero_a, man_a};
    end
    exp_diff  = exp_l - exp_s;
    mant_s_al = (32'(exp_diff) >= DpW) ? '0 : (mant_s >> exp_diff);
  end

  // Stage 1 register: ordered, aligned operand pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_sub_q    <= 1'b0;
      s1_inf_q    <= 1'b0;
      s1_exp_q    <= '0;
      s1_mant_l_q <= '0;
      s1_mant_s_q <= '0;
    end else if (advance) begin
      s1_valid_q  <= in_valid;
      s1_sign_q   <= a_larger ? sign_a : sign_b;
      s1_sub_q    <= sign_a ^ sign_b;
      s1_inf_q    <= inf_any;
      s1_exp_q    <= exp_l;
      s1_mant_l_q <= mant_l;
      s1_mant_s_q <= mant_s_al;
    end
  end

  // Larger magnitude is first, so the difference never goes negative.
  assign sum_d = s1_sub_q ? (s1_mant_l_q - s1_mant_s_q) : (s1_mant_l_q + s1_mant_s_q);

  // Stage 2 register: raw mantissa sum with the larger operand's exponent and sign.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_inf_q   <= 1'b0;
      s2_exp_q   <= '0;
      s2_sum_q   <= '0;
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s1_sign_q;
      s2_inf_q   <= s1_inf_q;
      s2_exp_q   <= s1_exp_q;
      s2_sum_q   <= sum_d;
    end
  end

  // Normalise, range-check the exponent and pack the result word.
  always_comb begin
    lz = '0;
    // Highest set bit below the carry position wins.
    for (int i = 0; i < DpW - 1; i++) begin
      if (s2_sum_q[i]) lz = ShW'(DpW - 2 - i);
    end
    if (s2_sum_q[DpW-1]) begin
      man_n = s2_sum_q >> 1;
      exp_n = ExW'(s2_exp_q) + ExW'(1'b1);
    end else begin
      man_n = s2_sum_q << lz;
      exp_n = ExW'(s2_exp_q) - ExW'(lz);
    end
    res_d = '0;
    exc_d = 1'b0;
    if (s2_inf_q) begin
      exc_d = 1'b1;
    end else if (s2_sum_q == '0) begin
      exc_d = 1'b0;
    end else if (!exp_n[ExW-1] && (exp_n >= ExW'(ExpMax))) begin
      exc_d = 1'b1;
    end else if (exp_n[ExW-1] || (exp_n == '0)) begin
      exc_d = 1'b0;
    end else begin
      res_d = {s2_sign_q, exp_n[EXP_W-1:0], man_n[MAN_W-1:0]};
    end
  end

  // Output register: holds steady while downstream stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      exc_q       <= 1'b0;
    end else if (advance) begin
      out_valid_q <= s2_valid_q;
      res_q       <= res_d;
      exc_q       <= exc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign exception = exc_q;

endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Self-checking bench for fp_add_sub_pipe: directed vectors, backpressure, mid-flight
// reset and a randomized stream scored against an arithmetic reference model.
module tb_fp_add_sub_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] res;
  logic        exception;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  logic [32:0] q_exp[$];

  fp_add_sub_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .exception (exception)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer mantissas, smaller one truncated by the exponent gap,
  // then renormalised into [2^23, 2^24). Result packed as {exception, word}.
  function automatic logic [32:0] model(input logic o, input logic [31:0] x,
                                        input logic [31:0] y);
    int     ex, ey, el, es, e, d;
    longint mx, my, ml, ms, r;
    logic   sx, sy, s;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    if (ex == 255 || ey == 255) return {1'b1, 32'h0};
    sx = x[31];
    sy = y[31] ^ o;
    mx = (ex == 0) ? 0 : (longint'(1) << 23) + longint'(x[22:0]);
    my = (ey == 0) ? 0 : (longint'(1) << 23) + longint'(y[22:0]);
    if (ex > ey || (ex == ey && mx >= my)) begin
      el = ex; es = ey; ml = mx; ms = my; s = sx;
    end else begin
      el = ey; es = ex; ml = my; ms = mx; s = sy;
    end
    d  = el - es;
    ms = (d >= 62) ? 0 : (ms >> d);
    r  = (sx == sy) ? ml + ms : ml - ms;
    if (r == 0) return 33'h0;
    e = el;
    while (r >= (longint'(1) << 24)) begin r = r / 2; e++; end
    while (r < (longint'(1) << 23)) begin r = r * 2; e--; end
    if (e >= 255) return {1'b1, 32'h0};
    if (e <= 0) return 33'h0;
    return {1'b0, s, 8'(e), 23'(r)};
  endfunction

  // Biased toward zeros, Inf/NaN, large exponents and nearby exponents.
  function automatic logic [31:0] rand_fp(input logic [31:0] ref_w);
    logic [31:0] w;
    int unsigned k;
    w = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0: w[30:23] = 8'd0;
      1: w[30:23] = 8'hFF;
      2: w[30:23] = 8'hFE;
      3, 4, 5: w[30:23] = ref_w[30:23] + 8'($urandom_range(0, 3));
      6: w[30:23] = 8'($urandom_range(1, 4));
      7: w = ref_w;
      default: ;
    endcase
    return w;
  endfunction

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    logic [32:0] held;
    logic        stall_q;
    held = '0;
    stall_q = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q_exp.delete();
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          check_eq("hold_valid", 64'(out_valid), 64'd1);
          check_eq("hold_data", 64'({exception, res}), 64'(held));
        end
        check_eq("in_ready_rel", 64'(in_ready), 64'(!out_valid || out_ready));
        if (in_valid && in_ready) q_exp.push_back(model(op, a, b));
        if (out_valid && out_ready) begin
          n_out++;
          if (q_exp.size() == 0) check_eq("sb_extra", 64'(q_exp.size()), 64'd1);
          else check_eq("sb_data", 64'({exception, res}), 64'(q_exp.pop_front()));
        end
        stall_q = out_valid && !out_ready;
        held    = {exception, res};
      end
    end
  end

  // Called just after a rising edge; holds the operands until accepted.
  task automatic send(input logic o, input logic [31:0] x, input logic [31:0] y);
    bit took;
    int n;
    took = 1'b0;
    n = 0;
    in_valid = 1'b1; op = o; a = x; b = y;
    while (!took) begin
      @(negedge clk);
      took = in_ready && !reset;
      @(posedge clk); #1;
      n++;
      if (!took && n > 64) begin
        check_eq("send_timeout", 64'(n), 64'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Single operation through an idle pipe: latency and result against constants.
  task automatic run_one(input string tag, input logic o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] er, input logic ee);
    int lat;
    out_ready = 1'b1;
    send(o, x, y);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
    check_eq({tag, "_lat"}, 64'(lat), 64'd3);
    check_eq({tag, "_res"}, 64'(res), 64'(er));
    check_eq({tag, "_exc"}, 64'(exception), 64'(ee));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (q_exp.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
    check_eq(tag, 64'(q_exp.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n6;
    bit done;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_res", 64'(res), 64'd0);
    check_eq("rst_exc", 64'(exception), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    run_one("add", 1'b0, 32'h4201_51EC, 32'h4242_147B, 32'h42A1_B333, 1'b0);
    run_one("sub_pos", 1'b1, 32'h40C0_0000, 32'h40A0_0000, 32'h3F80_0000, 1'b0);
    run_one("sub_neg", 1'b1, 32'h40A0_0000, 32'h40C0_0000, 32'hBF80_0000, 1'b0);
    run_one("add_negs", 1'b0, 32'hC0A0_0000, 32'hC0C0_0000, 32'hC130_0000, 1'b0);
    run_one("cancel", 1'b1, 32'h4B7F_FFFF, 32'h4B7F_FFFF, 32'h0000_0000, 1'b0);
    run_one("trunc", 1'b0, 32'h4B7F_FFFF, 32'h4000_0000, 32'h4B80_0000, 1'b0);
    run_one("zero_a", 1'b0, 32'h0000_0000, 32'h3EC7_AE14, 32'h3EC7_AE14, 1'b0);
    run_one("zero_a_sub", 1'b1, 32'h0000_0000, 32'h3EC7_AE14, 32'hBEC7_AE14, 1'b0);
    run_one("inf", 1'b0, 32'h7F80_0000, 32'h3EC7_AE14, 32'h0000_0000, 1'b1);
    run_one("ovf", 1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h0000_0000, 1'b1);
    run_one("unf", 1'b1, 32'h0080_0001, 32'h0080_0000, 32'h0000_0000, 1'b0);

    // Six back-to-back operations with a four-cycle stall on the first result.
    n6 = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) send(1'($urandom_range(0, 1)), rand_fp($urandom),
                                         32'h3F80_0000 + 32'($urandom_range(0, 255)));
      end
      begin
        int n;
        logic [31:0] h;
        n = 0;
        out_ready = 1'b0;
        @(negedge clk);
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        check_eq("bp_latency", 64'(n), 64'd3);
        h = res;
        for (int k = 0; k < 4; k++) begin
          if (k != 0) begin
            @(negedge clk);
            check_eq("bp_res_hold", 64'(res), 64'(h));
          end
          check_eq("bp_in_ready", 64'(in_ready), 64'd0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    check_eq("bp_count", 64'(n_out - n6), 64'd6);

    // Reset while two operations are in flight, with inputs offered during reset.
    out_ready = 1'b1;
    send(1'b0, 32'h3F80_0000, 32'h4000_0000);
    send(1'b1, 32'h4040_0000, 32'h3F80_0000);
    reset = 1'b1;
    in_valid = 1'b1; op = 1'b0; a = 32'h3F80_0000; b = 32'h3F80_0000;
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("rst_flush", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    run_one("post_rst", 1'b0, 32'h4201_51EC, 32'h4242_147B, 32'h42A1_B333, 1'b0);

    // Randomized stream with random gaps and random backpressure.
    done = 1'b0;
    fork
      begin
        logic [31:0] x, y;
        for (int i = 0; i < 300; i++) begin
          in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          x = rand_fp($urandom);
          y = rand_fp(x);
          send(1'($urandom_range(0, 1)), x, y);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    drain("rand_drain");
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    check_eq("final_idle", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_add_sub_pipe.md
FP_ADD_SUB_PIPE -- requirements
Module: fp_add_sub_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, stored mantissa field width, with the hidden bit implied.
REQ-003 Word width W SHALL equal 1+EXP_W+MAN_W, which is 32 by default. Format is sign, then exponent, then mantissa, MSB first, with bias 2^(EXP_W-1)-1.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  operand pair and op are valid.
REQ-008 in_ready  out  1  block accepts the operands this cycle.
REQ-009 op  in  1  operation select: 0 = a+b, 1 = a-b.
REQ-010 a  in  W  operand A.
REQ-011 b  in  W  operand B.
REQ-012 out_valid  out  1  res and exception are valid.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 res  out  W  result.
REQ-015 exception  out  1  an operand is Inf/NaN, or the result overflowed.

Function
REQ-016 Operands are transferred when in_valid and in_ready are both 1. Results are transferred when out_valid and out_ready are both 1.
REQ-017 Pipeline is 3 stages, with latency exactly 3 cycles from input transfer to out_valid when there are no stalls.
REQ-018 Stage S1: unpack, apply op by XORing b's sign, compare magnitudes, swap so the larger magnitude is first, and right-shift-align the smaller mantissa. The shift saturates at MAN_W+2.
REQ-019 Stage S2: add or subtract the aligned mantissas (with hidden bit) on an MAN_W+2 bit datapath. Result sign is the sign of the larger-magnitude operand.
REQ-020 Stage S3: normalise (1-bit right shift on carry, or leading-zero left shift), adjust the exponent, and pack.
REQ-021 Rounding is truncation toward zero; no guard/sticky rounding.
REQ-022 An operand with exponent field 0 is treated as zero (subnormals are flushed). A zero operand passes the other operand through unchanged, including the op sign flip.
REQ-023 Exact cancellation, and zero-plus-zero, produce +0 (all bits 0).
REQ-024 If an operand has an all-ones exponent (Inf/NaN), res is all 0 and exception is 1.
REQ-025 If the normalised exponent reaches all-ones (overflow), res is all 0 and exception is 1.
REQ-026 If the normalised exponent underflows to 0 or below, res is +0 and exception is 0.
REQ-027 Flow control is a global stall: all stages advance iff (!out_valid || out_ready).
REQ-028 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-029 Each stage carries a valid bit. Bubbles propagate, and output valid bits are never dropped or duplicated.
REQ-030 While stalled (out_valid=1 and out_ready=0), res, exception and out_valid SHALL hold stable.
REQ-031 Throughput is 1 result per cycle while out_ready=1.
REQ-032 Ordering: results emerge in input order.
REQ-033 Input transfer and output transfer in the same cycle are both honoured.
REQ-034 Combinational path from out_ready to in_ready is permitted. There is no combinational path from a, b or op to any output.

Reset
REQ-035 When reset=1 at a rising edge, all stage valid bits, out_valid, res and exception SHALL be cleared to 0.
REQ-036 in_ready reads 1 in the cycle after reset.
REQ-037 Reset asserted mid-operation discards all in-flight operations. No result from them appears after reset deasserts.
REQ-038 Inputs presented while reset=1 are not accepted.

Verification
REQ-039 Add, 3-cycle latency: op=0, a=4201_51EC, b=4242_147B, one transfer -> out_valid=1 exactly 3 cycles later, res=42A1_B333, exception=0.
REQ-040 Subtract and sign: op=1, a=40C0_0000, b=40A0_0000 -> res=3F80_0000. op=1, a=40A0_0000, b=40C0_0000 -> res=BF80_0000. op=0, a=C0A0_0000, b=C0C0_0000 -> res=C130_0000.
REQ-041 Cancellation and truncation:
- op=1, a=b=4B7F_FFFF -> res=0000_0000.
- op=0, a=4B7F_FFFF, b=4000_0000 -> res=4B80_0000.
- op=0, a=0000_0000, b=3EC7_AE14 -> res=3EC7_AE14.
REQ-042 Exceptions: a=7F80_0000, b=3EC7_AE14 -> res=0, exception=1. a=b=7F7F_FFFF, op=0 -> res=0, exception=1.
REQ-043 Backpressure: stream 6 back-to-back operations, hold out_ready=0 for 4 cycles after the first out_valid, then release -> in_ready=0 during the stall, res held stable, all 6 results delivered in order with none lost or duplicated.
REQ-044 Reset mid-flight: issue 2 operations, assert reset for 1 cycle before either completes -> out_valid stays 0 afterwards. A new operation then completes with 3-cycle latency.
